// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite master.
// State encoding, response codes and default bus widths.
package axil_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_RD_ADDR      = 3'd1,
        ST_RD_DATA      = 3'd2,
        ST_WR_ADDR_DATA = 3'd3,
        ST_WR_RESP      = 3'd4,
        ST_RSP          = 3'd5
    } state_e;

endpackage

// File: rtl/axil_handshake_reg.sv
// Valid/ready holding register for one AXI request channel.
// Payload is loaded with valid and held until the ready handshake.
module axil_handshake_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/axil_lite_master.sv
// One-outstanding AXI4-Lite master behind a command/response port.
// Define AXIL_MASTER_TIMEOUT_EN to build the sticky watchdog flag.
module axil_lite_master #(
`ifdef AXIL_MASTER_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 1024,
`endif
    parameter int ADDR_W = axil_pkg::ADDR_W,
    parameter int DATA_W = axil_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_write,
    output logic              timeout,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    import axil_pkg::*;

    state_e            state_q, state_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_write_q, rsp_write_d;

    logic              accept;
    logic              aw_done;
    logic              w_done;
    logic [DATA_W+3:0] w_bundle;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    axil_handshake_reg #(.W(ADDR_W)) u_aw (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && cmd_write),
        .load_data (cmd_addr),
        .ready     (m_axi_awready),
        .valid     (m_axi_awvalid),
        .data      (m_axi_awaddr)
    );

    axil_handshake_reg #(.W(DATA_W + 4)) u_w (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && cmd_write),
        .load_data ({cmd_wstrb, cmd_wdata}),
        .ready     (m_axi_wready),
        .valid     (m_axi_wvalid),
        .data      (w_bundle)
    );

    axil_handshake_reg #(.W(ADDR_W)) u_ar (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && !cmd_write),
        .load_data (cmd_addr),
        .ready     (m_axi_arready),
        .valid     (m_axi_arvalid),
        .data      (m_axi_araddr)
    );

    assign m_axi_wstrb = w_bundle[DATA_W+3:DATA_W];
    assign m_axi_wdata = w_bundle[DATA_W-1:0];

    // A channel is done once its valid is gone or is being accepted now.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid || m_axi_wready;

    always_comb begin
        state_d     = state_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR_DATA: begin
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi_bresp;
                    rsp_write_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_ADDR: begin
                if (m_axi_arvalid && m_axi_arready) begin
                    rready_d = 1'b1;
                    state_d  = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axi_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_write_d = 1'b0;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                bready_d    = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            rsp_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
        end
    end

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_bready = bready_q;
    assign m_axi_rready = rready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_resp     = rsp_resp_q;
    assign rsp_write    = rsp_write_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Counts cycles spent waiting on the bus in the current state.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_d != state_q || state_q == ST_IDLE || state_q == ST_RSP) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(TIMEOUT_CYC)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == CW'(TIMEOUT_CYC)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule
